odd_issue_ctrl: RTL and testbench
=================================

Name: odd_issue_ctrl

Overview:
- Issue scheduler sitting in front of the SPU odd pipe (permute p1, local store ls1, branch br1).
- Buffers decoded odd-pipe instructions in a small FIFO and holds the head on RAW/WAW hazards and on odd-pipe write-back port collisions.
- Issues at most one instruction per cycle with registered issue outputs.
- Enforces a one-cycle branch shadow and flushes queued work on a taken branch.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2)
- LAT_PERM, 4, cycles from issue_valid to p1 write-back
- LAT_LS, 6, cycles from issue_valid to ls1 write-back
- LAT_BR, 1, cycles from issue_valid to br1 link write-back
- SB_DEPTH, 7, scoreboard slots; must be > max(LAT_*)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready
- in_unit  in  2  0=permute, 1=local store, 2=branch, 3=nop (no unit)
- in_op_code  in  11  opcode, passed through
- in_instr_format  in  3  format, passed through
- in_dest  in  7  destination register
- in_reg_write  in  1  instruction writes in_dest
- in_src_a, in_src_b, in_src_c  in  7 each  source register addresses (c = store/rt source)
- in_use_a, in_use_b, in_use_c  in  1 each  source valid flags
- in_pc  in  8  program counter
- branch_taken  in  1  from br1; taken-branch flush
- issue_valid  out  1  instruction presented to odd pipe this cycle
- issue_unit, issue_op_code, issue_instr_format, issue_dest, issue_reg_write, issue_pc  out  2/11/3/7/1/8  registered copies of FIFO head fields
- stall_count  out  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset==0 at posedge): FIFO and scoreboard cleared, shadow cleared; all outputs 0; in_ready=0 while reset low.
- FIFO: push on in_valid & in_ready; in_ready = !full.
  - Simultaneous push and pop when full is not allowed: in_ready depends only on the registered full flag.
  - Push and pop in the same cycle when not full is allowed.
- Scoreboard: SB_DEPTH slots {valid, addr}; shifts down one slot per posedge; slot 0 is dropped after its cycle.
  - An issued instruction with reg_write and unit≠3 is inserted at slot LAT-1 (LAT chosen by unit) at the issue edge.
  - The register is therefore pending for exactly LAT cycles, starting with the issue_valid cycle.
- Issue decision, combinational on the FIFO head in cycle c. The head issues (pop; issue_valid=1 in c+1) when the FIFO is non-empty, not in shadow, branch_taken=0, and no hazard.
- Hazard conditions (any one stalls):
  - (a) RAW: any used source equals a valid slot addr.
  - (b) WAW: head reg_write and in_dest equals a valid slot addr.
  - (c) Write-back collision: head reg_write and pre-shift slot[LAT] valid.
- A stall leaves the head in place, sets issue_valid=0, and increments stall_count (saturates at 16'hFFFF).
- Branch shadow: issuing unit 2 sets shadow for the next cycle; no issue is decided in that cycle.
- Taken branch: branch_taken=1 empties the FIFO, blocks issue and push that cycle, and clears shadow.
  - In-flight scoreboard entries are kept; all are older than the branch.
- Unit 3: issues with issue_valid=1 and no scoreboard insert.
- Register address 0 is treated like any other register.

Optional Feature:
- Macro ODD_ISSUE_FWD_EN.
- Defined: a RAW match against slot 0 only is not a hazard, because the result is forwarded from the write-back stage. Consumer gap is LAT cycles.
- Undefined: slot 0 matches stall. Consumer gap is LAT+1 cycles.
- WAW and collision rules are identical in both builds.

Test Plan:
1. Hold reset=0 for 2 cycles with in_valid=1 -> in_ready=0, issue_valid=0, stall_count=0; after release in_ready=1 and the first instruction issues 2 cycles after push.
2. Two independent permutes (r3←r1,r2; r4←r5,r6) pushed back-to-back -> issue_valid high on consecutive cycles, stall_count stays 0.
3. Load (unit 1, dest r3) issued at cycle T, then permute reading r3 -> permute issue_valid at T+7 with stall_count=6; with ODD_ISSUE_FWD_EN, at T+6 with stall_count=5.
4. Load r3 at T, unit-3 nop at T+1, permute r9←r1,r2 -> one-cycle collision stall; permute issues at T+3, stall_count=1.
5. Branch issues at T with 3 entries queued; branch_taken=1 at T+1 -> issue_valid=0 at T+1 and T+2, FIFO empty, in_ready=1; next pushed instruction issues normally.
6. Assert reset=0 at T+2 after a load r3 issue, then push a permute reading r3 -> scoreboard is clear, so the permute issues without stall.

Source files
------------

// File: rtl/odd_issue_ctrl_if.sv
// rtl/odd_issue_ctrl_if.sv - decoded-instruction intake and odd-pipe issue bundle
// master drives instructions and branch resolution; slave is the issue controller.

interface odd_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_unit;
  logic [10:0] in_op_code;
  logic [2:0]  in_instr_format;
  logic [6:0]  in_dest;
  logic        in_reg_write;
  logic [6:0]  in_src_a;
  logic [6:0]  in_src_b;
  logic [6:0]  in_src_c;
  logic        in_use_a;
  logic        in_use_b;
  logic        in_use_c;
  logic [7:0]  in_pc;
  logic        branch_taken;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic [10:0] issue_op_code;
  logic [2:0]  issue_instr_format;
  logic [6:0]  issue_dest;
  logic        issue_reg_write;
  logic [7:0]  issue_pc;
  logic [15:0] stall_count;

  modport master (
    output in_valid, in_unit, in_op_code, in_instr_format, in_dest, in_reg_write,
           in_src_a, in_src_b, in_src_c, in_use_a, in_use_b, in_use_c, in_pc,
           branch_taken,
    input  in_ready, issue_valid, issue_unit, issue_op_code, issue_instr_format,
           issue_dest, issue_reg_write, issue_pc, stall_count
  );

  modport slave (
    input  in_valid, in_unit, in_op_code, in_instr_format, in_dest, in_reg_write,
           in_src_a, in_src_b, in_src_c, in_use_a, in_use_b, in_use_c, in_pc,
           branch_taken,
    output in_ready, issue_valid, issue_unit, issue_op_code, issue_instr_format,
           issue_dest, issue_reg_write, issue_pc, stall_count
  );
endinterface

// File: rtl/odd_issue_ctrl.sv
// rtl/odd_issue_ctrl.sv - odd-pipe issue scheduler with hazard scoreboard and branch shadow
// Optional ODD_ISSUE_FWD_EN: slot-0 RAW matches are forwarded instead of stalling.

module odd_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LAT_PERM   = 4,
  parameter int LAT_LS     = 6,
  parameter int LAT_BR     = 1,
  parameter int SB_DEPTH   = 7
) (
  input  logic              clock,
  input  logic              reset,
  odd_issue_ctrl_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SB_DEPTH);
`ifdef ODD_ISSUE_FWD_EN
  localparam int RAW_LO = 1;
`else
  localparam int RAW_LO = 0;
`endif

  typedef struct packed {
    logic [1:0]  unit;
    logic [10:0] op_code;
    logic [2:0]  instr_format;
    logic [6:0]  dest;
    logic        reg_write;
    logic [6:0]  src_a;
    logic [6:0]  src_b;
    logic [6:0]  src_c;
    logic        use_a;
    logic        use_b;
    logic        use_c;
    logic [7:0]  pc;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  entry_t        in_entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          push;
  logic          shadow;
  logic          sb_valid [SB_DEPTH];
  logic [6:0]    sb_addr  [SB_DEPTH];
  logic [SW-1:0] head_lat;
  logic          raw;
  logic          waw;
  logic          coll;
  logic          can_decide;
  logic          do_issue;
  logic          do_stall;
  logic          sb_ins;

  // Ready is a function of registered occupancy only; a taken branch refuses the push.
  assign full         = (count == (PW+1)'(FIFO_DEPTH));
  assign bus.in_ready = reset && !full && !bus.branch_taken;
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];

  always_comb begin
    in_entry = '{unit: bus.in_unit, op_code: bus.in_op_code,
                 instr_format: bus.in_instr_format, dest: bus.in_dest,
                 reg_write: bus.in_reg_write, src_a: bus.in_src_a,
                 src_b: bus.in_src_b, src_c: bus.in_src_c, use_a: bus.in_use_a,
                 use_b: bus.in_use_b, use_c: bus.in_use_c, pc: bus.in_pc};
  end

  always_comb begin
    head_lat = SW'(LAT_BR);
    case (head.unit)
      2'd0:    head_lat = SW'(LAT_PERM);
      2'd1:    head_lat = SW'(LAT_LS);
      default: head_lat = SW'(LAT_BR);
    endcase
    raw = 1'b0;
    waw = 1'b0;
    for (int i = RAW_LO; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && ((head.use_a && head.src_a == sb_addr[i]) ||
                          (head.use_b && head.src_b == sb_addr[i]) ||
                          (head.use_c && head.src_c == sb_addr[i])))
        raw = 1'b1;
    end
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && head.reg_write && head.dest == sb_addr[i])
        waw = 1'b1;
    end
    // The slot about to shift into LAT-1 would share the write-back cycle.
    coll       = head.reg_write && (head.unit != 2'd3) && sb_valid[head_lat];
    can_decide = (count != '0) && !shadow && !bus.branch_taken;
    do_issue   = can_decide && !(raw || waw || coll);
    do_stall   = can_decide && (raw || waw || coll);
    sb_ins     = do_issue && head.reg_write && (head.unit != 2'd3);
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= '0;
      shadow                 <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_valid[i] <= 1'b0;
        sb_addr[i]  <= '0;
      end
      bus.issue_valid        <= 1'b0;
      bus.issue_unit         <= '0;
      bus.issue_op_code      <= '0;
      bus.issue_instr_format <= '0;
      bus.issue_dest         <= '0;
      bus.issue_reg_write    <= 1'b0;
      bus.issue_pc           <= '0;
      bus.stall_count        <= '0;
    end else begin
      if (bus.branch_taken) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (do_issue)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, do_issue})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      shadow <= do_issue && (head.unit == 2'd2);

      for (int i = 0; i < SB_DEPTH - 1; i++) begin
        sb_valid[i] <= sb_valid[i+1];
        sb_addr[i]  <= sb_addr[i+1];
      end
      sb_valid[SB_DEPTH-1] <= 1'b0;
      sb_addr[SB_DEPTH-1]  <= '0;
      if (sb_ins) begin
        sb_valid[head_lat - SW'(1)] <= 1'b1;
        sb_addr[head_lat - SW'(1)]  <= head.dest;
      end

      bus.issue_valid <= do_issue;
      if (do_issue) begin
        bus.issue_unit         <= head.unit;
        bus.issue_op_code      <= head.op_code;
        bus.issue_instr_format <= head.instr_format;
        bus.issue_dest         <= head.dest;
        bus.issue_reg_write    <= head.reg_write;
        bus.issue_pc           <= head.pc;
      end
      if (do_stall && bus.stall_count != 16'hFFFF)
        bus.stall_count <= bus.stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// tb/tb_odd_issue_ctrl.sv - directed self-checking bench for odd_issue_ctrl
// Honors ODD_ISSUE_FWD_EN when compiled with it.

module tb_odd_issue_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   gap;

`ifdef ODD_ISSUE_FWD_EN
  localparam int RAW_GAP   = 6;
  localparam int RAW_STALL = 5;
`else
  localparam int RAW_GAP   = 7;
  localparam int RAW_STALL = 6;
`endif

  odd_issue_ctrl_if bus ();

  odd_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_instr(input logic [1:0] unit, input logic [6:0] dest, input logic rw,
                           input logic [6:0] sa, input logic ua,
                           input logic [6:0] sb, input logic ub, input logic [7:0] pc);
    bus.in_valid        = 1'b1;
    bus.in_unit         = unit;
    bus.in_op_code      = {3'b101, pc};
    bus.in_instr_format = 3'd2;
    bus.in_dest         = dest;
    bus.in_reg_write    = rw;
    bus.in_src_a        = sa;
    bus.in_use_a        = ua;
    bus.in_src_b        = sb;
    bus.in_use_b        = ub;
    bus.in_src_c        = 7'd0;
    bus.in_use_c        = 1'b0;
    bus.in_pc           = pc;
  endtask

  // Leaves reset released in the current cycle with inputs idle.
  task automatic do_reset();
    reset            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.branch_taken = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic wait_issue(output int g);
    g = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (bus.issue_valid) begin
        g = k;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.branch_taken = 1'b0;
    set_instr(2'd0, 7'd7, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h10);

    // Reset with in_valid held high
    cycle();
    cycle();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("rst_stall_count", {16'd0, bus.stall_count}, 32'd0);
    check("rst_issue_dest", {25'd0, bus.issue_dest}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle();
    idle();
    check("rel_issue_early", {31'd0, bus.issue_valid}, 32'd0);
    cycle();
    check("rel_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("rel_issue_dest", {25'd0, bus.issue_dest}, 32'd7);

    // Two independent permutes back to back
    do_reset();
    set_instr(2'd0, 7'd3, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h20);
    cycle();
    set_instr(2'd0, 7'd4, 1'b1, 7'd5, 1'b1, 7'd6, 1'b1, 8'h21);
    cycle();
    idle();
    check("b2b_valid0", {31'd0, bus.issue_valid}, 32'd1);
    check("b2b_dest0", {25'd0, bus.issue_dest}, 32'd3);
    check("b2b_pc0", {24'd0, bus.issue_pc}, 32'h20);
    check("b2b_op0", {21'd0, bus.issue_op_code}, 32'h520);
    cycle();
    check("b2b_valid1", {31'd0, bus.issue_valid}, 32'd1);
    check("b2b_dest1", {25'd0, bus.issue_dest}, 32'd4);
    check("b2b_fmt1", {29'd0, bus.issue_instr_format}, 32'd2);
    cycle();
    check("b2b_valid2", {31'd0, bus.issue_valid}, 32'd0);
    check("b2b_stall", {16'd0, bus.stall_count}, 32'd0);

    // Load r3 then permute consuming r3
    do_reset();
    set_instr(2'd1, 7'd3, 1'b1, 7'd1, 1'b1, 7'd2, 1'b0, 8'h30);
    cycle();
    set_instr(2'd0, 7'd4, 1'b1, 7'd3, 1'b1, 7'd2, 1'b1, 8'h31);
    cycle();
    idle();
    check("raw_load_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("raw_load_unit", {30'd0, bus.issue_unit}, 32'd1);
    wait_issue(gap);
    check("raw_gap", gap, RAW_GAP);
    check("raw_dest", {25'd0, bus.issue_dest}, 32'd4);
    check("raw_stall", {16'd0, bus.stall_count}, RAW_STALL);

    // Load r3, nop, permute r9: write-back port collision
    do_reset();
    set_instr(2'd1, 7'd3, 1'b1, 7'd1, 1'b1, 7'd2, 1'b0, 8'h40);
    cycle();
    set_instr(2'd3, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 8'h41);
    cycle();
    check("col_load_valid", {31'd0, bus.issue_valid}, 32'd1);
    set_instr(2'd0, 7'd9, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h42);
    cycle();
    idle();
    check("col_nop_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("col_nop_unit", {30'd0, bus.issue_unit}, 32'd3);
    wait_issue(gap);
    check("col_gap", gap, 2);
    check("col_dest", {25'd0, bus.issue_dest}, 32'd9);
    check("col_stall", {16'd0, bus.stall_count}, 32'd1);

    // Branch held behind a load, three entries queued, then taken
    do_reset();
    set_instr(2'd1, 7'd5, 1'b1, 7'd1, 1'b0, 7'd2, 1'b0, 8'h50);
    cycle();
    set_instr(2'd2, 7'd0, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0, 8'h51);
    cycle();
    set_instr(2'd0, 7'd10, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h52);
    cycle();
    set_instr(2'd0, 7'd11, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h53);
    cycle();
    set_instr(2'd0, 7'd12, 1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 8'h54);
    cycle();
    idle();
    check("br_full_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_issue(gap);
    check("br_found", {31'd0, gap != 0}, 32'd1);
    check("br_unit", {30'd0, bus.issue_unit}, 32'd2);
    check("br_pc", {24'd0, bus.issue_pc}, 32'h51);
    cycle();
    check("br_shadow", {31'd0, bus.issue_valid}, 32'd0);
    bus.branch_taken = 1'b1;
    set_instr(2'd0, 7'd13, 1'b1, 7'd1, 1'b0, 7'd2, 1'b0, 8'h55);
    #1;
    check("br_taken_ready", {31'd0, bus.in_ready}, 32'd0);
    cycle();
    bus.branch_taken = 1'b0;
    idle();
    #1;
    check("br_flush_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("br_flush_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle();
    check("br_empty_a", {31'd0, bus.issue_valid}, 32'd0);
    cycle();
    check("br_empty_b", {31'd0, bus.issue_valid}, 32'd0);
    set_instr(2'd0, 7'd14, 1'b1, 7'd1, 1'b0, 7'd2, 1'b0, 8'h56);
    cycle();
    idle();
    cycle();
    check("br_next_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("br_next_dest", {25'd0, bus.issue_dest}, 32'd14);

    // Reset while a load is in flight clears the scoreboard
    do_reset();
    set_instr(2'd1, 7'd3, 1'b1, 7'd1, 1'b0, 7'd2, 1'b0, 8'h60);
    cycle();
    idle();
    cycle();
    check("mid_load_valid", {31'd0, bus.issue_valid}, 32'd1);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("mid_rst_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("mid_rst_stall", {16'd0, bus.stall_count}, 32'd0);
    set_instr(2'd0, 7'd8, 1'b1, 7'd3, 1'b1, 7'd3, 1'b1, 8'h61);
    cycle();
    idle();
    cycle();
    check("mid_perm_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("mid_perm_dest", {25'd0, bus.issue_dest}, 32'd8);
    check("mid_perm_stall", {16'd0, bus.stall_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
